// File: rtl/elastic_pipe.sv
// Valid/ready circular buffer of DEPTH entries with synchronous flush and an
// optional combinational ready pass-through when full.
module elastic_pipe #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned DEPTH      = 2,
  parameter bit          READY_PASS = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         i_valid,
  output logic                         i_ready,
  input  logic [WIDTH-1:0]             i_data,
  output logic                         o_valid,
  input  logic                         o_ready,
  output logic [WIDTH-1:0]             o_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             push;
  logic             pop;

  // Exact wrap so non-power-of-2 depths never index past the last entry.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    o_valid = (cnt != '0) & ~flush;
    o_data  = mem[rd_ptr];
    i_ready = ~flush & ((cnt < FULL) | (READY_PASS & (cnt == FULL) & o_ready));
    push    = i_valid & i_ready;
    pop     = o_valid & o_ready;
    count   = cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      // When full with pass-through, wr_ptr == rd_ptr: the head is read this
      // cycle and its slot is overwritten at this edge.
      if (push) begin
        mem[wr_ptr] <= i_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_elastic_pipe.sv
// Scoreboard bench for elastic_pipe across four depth / pass-through variants.
module tb_elastic_pipe;

  logic       clk;
  logic       rst;
  logic       fl  [4];
  logic       iv  [4];
  logic       ir  [4];
  logic [7:0] id  [4];
  logic       ov  [4];
  logic       orr [4];
  logic [7:0] od  [4];
  logic [1:0] cnt [4];
  logic       cnt_d1;

  logic [7:0] exp_q [4][$];
  int         pops  [4];
  int         tests;
  int         fails;

  // 0: DEPTH=3 RP=0, 1: DEPTH=2 RP=1, 2: DEPTH=2 RP=0, 3: DEPTH=1 RP=1
  elastic_pipe #(.WIDTH(8), .DEPTH(3), .READY_PASS(1'b0)) u_a (
    .clk(clk), .rst(rst), .flush(fl[0]), .i_valid(iv[0]), .i_ready(ir[0]),
    .i_data(id[0]), .o_valid(ov[0]), .o_ready(orr[0]), .o_data(od[0]), .count(cnt[0]));
  elastic_pipe #(.WIDTH(8), .DEPTH(2), .READY_PASS(1'b1)) u_b (
    .clk(clk), .rst(rst), .flush(fl[1]), .i_valid(iv[1]), .i_ready(ir[1]),
    .i_data(id[1]), .o_valid(ov[1]), .o_ready(orr[1]), .o_data(od[1]), .count(cnt[1]));
  elastic_pipe #(.WIDTH(8), .DEPTH(2), .READY_PASS(1'b0)) u_c (
    .clk(clk), .rst(rst), .flush(fl[2]), .i_valid(iv[2]), .i_ready(ir[2]),
    .i_data(id[2]), .o_valid(ov[2]), .o_ready(orr[2]), .o_data(od[2]), .count(cnt[2]));
  elastic_pipe #(.WIDTH(8), .DEPTH(1), .READY_PASS(1'b1)) u_d (
    .clk(clk), .rst(rst), .flush(fl[3]), .i_valid(iv[3]), .i_ready(ir[3]),
    .i_data(id[3]), .o_valid(ov[3]), .o_ready(orr[3]), .o_data(od[3]), .count(cnt_d1));
  assign cnt[3] = {1'b0, cnt_d1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expected words on each output handshake, records accepted inputs.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst || fl[k]) begin
        exp_q[k].delete();
      end else begin
        if (ov[k] && orr[k]) begin
          pops[k]++;
          if (exp_q[k].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output dut%0d: got 0x%0h expected none", k, od[k]);
          end else begin
            chk($sformatf("pop_data_dut%0d", k), {24'd0, od[k]}, {24'd0, exp_q[k].pop_front()});
          end
        end
        if (iv[k] && ir[k]) exp_q[k].push_back(id[k]);
      end
    end
  end

  initial begin
    int w;
    int p0;
    int guard;
    tests = 0;
    fails = 0;
    for (int k = 0; k < 4; k++) begin
      fl[k] = 1'b0; iv[k] = 1'b1; id[k] = 8'hAA; orr[k] = 1'b0; pops[k] = 0;
    end
    rst = 1'b1;

    // Reset held two cycles with i_valid high.
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_o_valid_dut%0d", k), {31'd0, ov[k]}, 32'd0);
      chk($sformatf("rst_count_dut%0d", k), {30'd0, cnt[k]}, 32'd0);
      chk($sformatf("rst_o_data_dut%0d", k), {24'd0, od[k]}, 32'd0);
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) iv[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) chk($sformatf("post_rst_i_ready_dut%0d", k), {31'd0, ir[k]}, 32'd1);

    // Fill / drain, DEPTH=3, READY_PASS=0.
    for (int i = 1; i <= 3; i++) begin
      cyc(); iv[0] = 1'b1; id[0] = 8'(i); orr[0] = 1'b0;
      @(negedge clk); chk("fill_i_ready", {31'd0, ir[0]}, 32'd1);
    end
    cyc(); id[0] = 8'h04;
    @(negedge clk);
    chk("full_count", {30'd0, cnt[0]}, 32'd3);
    chk("full_i_ready", {31'd0, ir[0]}, 32'd0);
    cyc();
    @(negedge clk); chk("held_count", {30'd0, cnt[0]}, 32'd3);
    for (int i = 1; i <= 3; i++) begin
      cyc(); iv[0] = 1'b0; orr[0] = 1'b1;
      @(negedge clk);
      chk("drain_o_valid", {31'd0, ov[0]}, 32'd1);
      chk("drain_o_data", {24'd0, od[0]}, 32'(i));
    end
    cyc();
    @(negedge clk);
    chk("drained_o_valid", {31'd0, ov[0]}, 32'd0);
    chk("drained_count", {30'd0, cnt[0]}, 32'd0);

    // Wrap, DEPTH=3: 10 words with o_ready toggling.
    p0 = pops[0];
    w = 0;
    guard = 0;
    while (w < 10 && guard < 200) begin
      cyc(); iv[0] = 1'b1; id[0] = 8'(8'h10 + w); orr[0] = (guard % 2 == 0);
      @(negedge clk);
      chk("wrap_count_le3", {31'd0, (cnt[0] <= 2'd3)}, 32'd1);
      if (ir[0]) w++;
      guard++;
    end
    chk("wrap_all_accepted", 32'(w), 32'd10);
    guard = 0;
    cyc(); iv[0] = 1'b0; orr[0] = 1'b1;
    @(negedge clk);
    while (ov[0] && guard < 10) begin
      cyc(); @(negedge clk); guard++;
    end
    chk("wrap_drained", {31'd0, ov[0]}, 32'd0);
    chk("wrap_pop_total", 32'(pops[0] - p0), 32'd10);

    // Full pass-through, DEPTH=2, READY_PASS=1.
    for (int i = 0; i < 2; i++) begin
      cyc(); iv[1] = 1'b1; id[1] = 8'(8'h20 + i); orr[1] = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      cyc(); iv[1] = 1'b1; id[1] = 8'(8'h22 + i); orr[1] = 1'b1;
      @(negedge clk);
      chk("pass_i_ready", {31'd0, ir[1]}, 32'd1);
      chk("pass_o_valid", {31'd0, ov[1]}, 32'd1);
      chk("pass_count", {30'd0, cnt[1]}, 32'd2);
      chk("pass_o_data", {24'd0, od[1]}, 32'(8'h20 + i));
    end
    cyc(); iv[1] = 1'b0;
    cyc();
    cyc(); @(negedge clk);
    chk("pass_drained", {31'd0, ov[1]}, 32'd0);

    // Same with READY_PASS=0: blocked while full, then one per cycle at count 1.
    for (int i = 0; i < 2; i++) begin
      cyc(); iv[2] = 1'b1; id[2] = 8'(8'h30 + i); orr[2] = 1'b0;
    end
    w = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(); iv[2] = 1'b1; id[2] = 8'(8'h32 + w); orr[2] = 1'b1;
      @(negedge clk);
      if (i == 0) begin
        chk("nopass_full_i_ready", {31'd0, ir[2]}, 32'd0);
        chk("nopass_full_count", {30'd0, cnt[2]}, 32'd2);
      end else begin
        chk("nopass_i_ready", {31'd0, ir[2]}, 32'd1);
        chk("nopass_count", {30'd0, cnt[2]}, 32'd1);
      end
      if (ir[2]) w++;
    end
    cyc(); iv[2] = 1'b0;
    guard = 0;
    @(negedge clk);
    while (ov[2] && guard < 10) begin
      cyc(); @(negedge clk); guard++;
    end
    chk("nopass_drained", {31'd0, ov[2]}, 32'd0);

    // Flush with a stored pair and a word offered upstream.
    cyc(); iv[1] = 1'b1; id[1] = 8'h05; orr[1] = 1'b0;
    cyc(); id[1] = 8'h06;
    cyc(); fl[1] = 1'b1; id[1] = 8'h07; orr[1] = 1'b1;
    @(negedge clk);
    chk("flush_o_valid", {31'd0, ov[1]}, 32'd0);
    chk("flush_i_ready", {31'd0, ir[1]}, 32'd0);
    cyc(); fl[1] = 1'b0; iv[1] = 1'b0; orr[1] = 1'b0;
    @(negedge clk);
    chk("post_flush_count", {30'd0, cnt[1]}, 32'd0);
    chk("post_flush_o_valid", {31'd0, ov[1]}, 32'd0);
    cyc(); fl[1] = 1'b1; iv[1] = 1'b1; id[1] = 8'h09;
    cyc();
    cyc(); fl[1] = 1'b0; id[1] = 8'h08;
    @(negedge clk);
    chk("first_after_flush_i_ready", {31'd0, ir[1]}, 32'd1);
    p0 = pops[1];
    cyc(); iv[1] = 1'b0; orr[1] = 1'b1;
    @(negedge clk);
    chk("after_flush_o_valid", {31'd0, ov[1]}, 32'd1);
    chk("after_flush_o_data", {24'd0, od[1]}, 32'h08);
    cyc(); @(negedge clk);
    chk("after_flush_empty", {31'd0, ov[1]}, 32'd0);
    chk("after_flush_pops", 32'(pops[1] - p0), 32'd1);

    // DEPTH=1, READY_PASS=1: full rate, one cycle behind.
    for (int i = 0; i < 8; i++) begin
      cyc(); iv[3] = 1'b1; id[3] = 8'(8'h40 + i); orr[3] = 1'b1;
      @(negedge clk);
      chk("d1_i_ready", {31'd0, ir[3]}, 32'd1);
      if (i == 0) begin
        chk("d1_first_o_valid", {31'd0, ov[3]}, 32'd0);
      end else begin
        chk("d1_o_valid", {31'd0, ov[3]}, 32'd1);
        chk("d1_o_data", {24'd0, od[3]}, 32'(8'h40 + i - 1));
      end
    end
    cyc(); iv[3] = 1'b0;
    @(negedge clk);
    chk("d1_last_o_data", {24'd0, od[3]}, 32'h47);
    cyc(); @(negedge clk);
    chk("d1_empty", {31'd0, ov[3]}, 32'd0);

    for (int k = 0; k < 4; k++) begin
      chk($sformatf("queue_empty_dut%0d", k), 32'(exp_q[k].size()), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/elastic_pipe.md
# elastic_pipe

Parametrised valid/ready pipeline buffer that replaces the fixed single-entry inter-stage registers, such as fetch→id and lsu→wb. It stores up to DEPTH payload words of WIDTH bits in a circular buffer. It adds a synchronous flush for branch/trap redirect and an optional combinational ready pass-through, so a full buffer still sustains one transfer per cycle. It sits between any two core stages and carries the packed stage payload (pc, inst, control) as one opaque bus.

## Interface
Parameters:
- WIDTH, 64: payload width in bits (≥1).
- DEPTH, 2: number of entries (≥1; non-power-of-2 allowed).
- READY_PASS, 1: 1 = i_ready also high when full and o_ready high; 0 = i_ready depends only on registered occupancy.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  drop all stored entries at next edge; highest priority after rst.
- i_valid  in  1  upstream has a payload.
- i_ready  out  1  buffer accepts the payload this cycle.
- i_data  in  WIDTH  upstream payload.
- o_valid  out  1  head entry is valid.
- o_ready  in  1  downstream accepts the head entry.
- o_data  out  WIDTH  head entry payload.
- count  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Storage: DEPTH×WIDTH registers; wr_ptr and rd_ptr of width max(1,$clog2(DEPTH)); occupancy register cnt.
- Pointer increment: ptr==DEPTH-1 → 0, else ptr+1. Wrap must be exact for non-power-of-2 DEPTH.
- o_valid = (cnt!=0) & ~flush. o_data = mem[rd_ptr] (combinational read of registered storage).
- i_ready = ~flush & ((cnt<DEPTH) | (READY_PASS & (cnt==DEPTH) & o_ready)).
- push = i_valid & i_ready; pop = o_valid & o_ready.
- push: mem[wr_ptr] ← i_data, wr_ptr advances. pop: rd_ptr advances.
- cnt next: push&~pop → +1; pop&~push → −1; both or neither → unchanged.
- Full with READY_PASS=1, push & pop in the same cycle: wr_ptr==rd_ptr. The head is read this cycle and the slot is overwritten at the edge. cnt stays DEPTH.
- Empty: no bypass. A pushed word is not visible on o_data until the next cycle.
- flush=1: at the edge, cnt←0, wr_ptr←0, rd_ptr←0. During the flush cycle, o_valid=0 and i_ready=0, so no transfer occurs. Storage contents are not cleared.
- rst=1: same as flush, and all storage words are set to 0. rst overrides flush and any handshake.
- Payload is never modified, reordered, duplicated or dropped except by flush or rst.
- Upstream must hold i_data stable while i_valid & ~i_ready. The block does not check this.

## Timing
- Reset values, in the cycle after rst with flush=0: o_valid=0, i_ready=1, count=0, o_data=0.
- Latency: push at edge N → o_valid=1 with that data in cycle N+1.
- Throughput: 1 word/cycle sustained for DEPTH≥2 with either READY_PASS, and for DEPTH=1 with READY_PASS=1. DEPTH=1 with READY_PASS=0 gives 1 word per 2 cycles.
- Combinational paths:
  - o_ready→i_ready exists only when READY_PASS=1.
  - flush→i_ready and flush→o_valid always exist.
  - No i_valid→o_valid path.
- count is registered and reflects state after the previous edge.
- Flush mid-stream with o_ready=1: the entry at the head is not popped. Both the word offered upstream and the head are lost.
- Back-to-back flushes keep the buffer empty. The first push is accepted in the first cycle with flush=0.

## Test plan
- Reset: hold rst 2 cycles with i_valid=1, i_data=0xAA → o_valid=0, count=0, o_data=0. Next cycle i_ready=1.
- Fill/drain, DEPTH=3, READY_PASS=0, o_ready=0: push 0x1,0x2,0x3 → count=3, i_ready=0, 4th word held. Raise o_ready → outputs 0x1,0x2,0x3 in consecutive cycles, then o_valid=0.
- Wrap, DEPTH=3: stream 10 words 0x10..0x19 with o_ready toggling 1,0,1,0… → output order 0x10..0x19 exact, no loss, count never >3.
- Full pass-through, DEPTH=2, READY_PASS=1: fill to 2, then i_valid=o_ready=1 for 5 cycles → one transfer per cycle, i_ready=1 throughout, count stays 2. Same with READY_PASS=0 → i_ready=0 while full.
- Flush: count=2 holding 0x5,0x6, assert flush with i_valid=o_ready=1, i_data=0x7 → that cycle o_valid=0, i_ready=0. Next cycle count=0, o_valid=0. A following push of 0x8 appears as the sole output.
- DEPTH=1, READY_PASS=1: continuous i_valid with incrementing data and o_ready=1 → output every cycle, one cycle behind input.
